block_interleaver: RTL

//  Row/column bit interleaver directly downstream of conv_encoder. Consumes the

---
 rtl/block_interleaver_pkg.sv | 17 +
 rtl/interleaver_bank.sv | 46 ++++
 rtl/block_interleaver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/block_interleaver_pkg.sv
// rtl/block_interleaver_pkg.sv - shared defaults, read FSM states and index helper for the block interleaver
package block_interleaver_pkg;

    localparam int ROWS_DEF = 16;
    localparam int COLS_DEF = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rd_state_e;

    // Storage index of output position j: row-major fill, column-major read.
    function automatic int col_major_index(input int j, input int rows, input int cols);
        return (j % rows) * cols + j / rows;
    endfunction

endpackage

// File: rtl/interleaver_bank.sv
// rtl/interleaver_bank.sv - two-bank bit store with two write ports and one two-bit read port
module interleaver_bank #(
    parameter int N_BITS = 48,
    parameter int IDX_W  = 6
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             wa_en,
    input  logic             wa_bank,
    input  logic [IDX_W-1:0] wa_idx,
    input  logic             wa_bit,
    input  logic             wb_en,
    input  logic             wb_bank,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic             wb_bit,
    input  logic             rd_bank,
    input  logic [IDX_W-1:0] rd_idx0,
    input  logic [IDX_W-1:0] rd_idx1,
    output logic [1:0]       rd_bits
);

    logic [1:0][N_BITS-1:0] mem_q;
    logic [1:0][N_BITS-1:0] mem_d;

    // The two write ports may target different banks in the same cycle (straddle).
    always_comb begin
        mem_d = mem_q;
        if (wa_en) begin
            mem_d[wa_bank][wa_idx] = wa_bit;
        end
        if (wb_en) begin
            mem_d[wb_bank][wb_idx] = wb_bit;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_bits = {mem_q[rd_bank][rd_idx0], mem_q[rd_bank][rd_idx1]};

endmodule

// File: rtl/block_interleaver.sv
// rtl/block_interleaver.sv - ping-pong row/column bit interleaver, row-wise fill and column-wise drain
module block_interleaver
    import block_interleaver_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [1:0] in_bits,
    input  logic [1:0] in_valid,
    output logic [1:0] out_bits,
    output logic [1:0] out_valid,
    output logic       out_sof,
    output logic       busy
);

    localparam int N_BITS  = ROWS * COLS;
    localparam int N_PAIRS = N_BITS / 2;
    localparam int IDX_W   = $clog2(N_BITS);
    localparam int PAIR_W  = $clog2(N_PAIRS);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_BITS - 1);
    localparam logic [IDX_W-1:0]  LAST2_IDX = IDX_W'(N_BITS - 2);
    localparam logic [IDX_W-1:0]  ONE_IDX   = IDX_W'(1);
    localparam logic [IDX_W-1:0]  TWO_IDX   = IDX_W'(2);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(N_PAIRS - 1);
    localparam logic [PAIR_W-1:0] ONE_PAIR  = PAIR_W'(1);

    logic [IDX_W-1:0]  wptr_q, wptr_d;
    logic              wbank_q, wbank_d;
    logic [1:0]        full_q, full_d;
    logic              rbank_q, rbank_d;
    logic [PAIR_W-1:0] rptr_q, rptr_d;
    rd_state_e         state_q, state_d;
    logic [1:0]        out_bits_q, out_bits_d;
    logic [1:0]        out_valid_q, out_valid_d;
    logic              out_sof_q, out_sof_d;

    logic              a_en, a_bit, a_bank, a_last;
    logic              b_en, b_bit, b_bank, b_last;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic              wr_complete;
    logic              ready_rd, ready_other;
    logic              present, drain_done;
    logic [PAIR_W-1:0] rd_pair;
    logic [IDX_W-1:0]  rd_idx0, rd_idx1;
    logic [1:0]        rd_bits;

    // Write side: A then B; a pair arriving at the last slot splits across banks.
    always_comb begin
        a_en    = |in_valid;
        a_bit   = in_valid[1] ? in_bits[1] : in_bits[0];
        b_en    = &in_valid;
        b_bit   = in_bits[0];
        a_bank  = wbank_q;
        a_idx   = wptr_q;
        a_last  = a_en && (wptr_q == LAST_IDX);
        b_bank  = a_last ? ~wbank_q : wbank_q;
        b_idx   = a_last ? '0 : wptr_q + ONE_IDX;
        b_last  = b_en && !a_last && (wptr_q == LAST2_IDX);
        wr_complete = a_last || b_last;

        wptr_d  = wptr_q;
        wbank_d = wbank_q;
        if (a_last) begin
            wptr_d  = b_en ? ONE_IDX : '0;
            wbank_d = ~wbank_q;
        end else if (b_last) begin
            wptr_d  = '0;
            wbank_d = ~wbank_q;
        end else if (b_en) begin
            wptr_d  = wptr_q + TWO_IDX;
        end else if (a_en) begin
            wptr_d  = wptr_q + ONE_IDX;
        end
    end

    // A bank completing this cycle counts as full so the drain can start on the same edge.
    always_comb begin
        ready_rd    = full_q[rbank_q] || (wr_complete && (wbank_q == rbank_q));
        ready_other = full_q[~rbank_q] || (wr_complete && (wbank_q != rbank_q));
    end

    always_comb begin
        state_d    = state_q;
        rptr_d     = rptr_q;
        rbank_d    = rbank_q;
        present    = 1'b0;
        drain_done = 1'b0;
        if (state_q == ST_IDLE) begin
            if (ready_rd) begin
                present = 1'b1;
                rptr_d  = ONE_PAIR;
                state_d = ST_DRAIN;
            end
        end else begin
            present = 1'b1;
            if (rptr_q == LAST_PAIR) begin
                drain_done = 1'b1;
                rptr_d     = '0;
                rbank_d    = ~rbank_q;
                state_d    = ready_other ? ST_DRAIN : ST_IDLE;
            end else begin
                rptr_d = rptr_q + ONE_PAIR;
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (wr_complete) begin
            full_d[wbank_q] = 1'b1;
        end
        if (drain_done) begin
            full_d[rbank_q] = 1'b0;
        end
    end

    assign rd_pair = (state_q == ST_DRAIN) ? rptr_q : '0;
    assign rd_idx0 = IDX_W'(col_major_index(2 * int'(rd_pair), ROWS, COLS));
    assign rd_idx1 = IDX_W'(col_major_index(2 * int'(rd_pair) + 1, ROWS, COLS));

    always_comb begin
        out_valid_d = present ? 2'b11 : 2'b00;
        out_bits_d  = present ? rd_bits : 2'b00;
        out_sof_d   = present && (rd_pair == '0);
    end

    interleaver_bank #(
        .N_BITS (N_BITS),
        .IDX_W  (IDX_W)
    ) u_bank (
        .Clk     (Clk),
        .reset   (reset),
        .wa_en   (a_en),
        .wa_bank (a_bank),
        .wa_idx  (a_idx),
        .wa_bit  (a_bit),
        .wb_en   (b_en),
        .wb_bank (b_bank),
        .wb_idx  (b_idx),
        .wb_bit  (b_bit),
        .rd_bank (rbank_q),
        .rd_idx0 (rd_idx0),
        .rd_idx1 (rd_idx1),
        .rd_bits (rd_bits)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            wptr_q      <= '0;
            wbank_q     <= 1'b0;
            full_q      <= 2'b00;
            rbank_q     <= 1'b0;
            rptr_q      <= '0;
            state_q     <= ST_IDLE;
            out_bits_q  <= 2'b00;
            out_valid_q <= 2'b00;
            out_sof_q   <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            wbank_q     <= wbank_d;
            full_q      <= full_d;
            rbank_q     <= rbank_d;
            rptr_q      <= rptr_d;
            state_q     <= state_d;
            out_bits_q  <= out_bits_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
        end
    end

    assign out_bits  = out_bits_q;
    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign busy      = (|full_q) || (wptr_q != '0) || (state_q == ST_DRAIN) || out_valid_q[1];

endmodule
